demux4_pipe: RTL and testbench
==============================

DEMUX4_PIPE -- requirements
Module: demux4_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the payload width in bits.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid  input  1  upstream payload valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a payload this cycle.
REQ-006 The block SHALL have port in_data  input  WIDTH  payload.
REQ-007 The block SHALL have port in_sel  input  2  destination channel 0..3.
REQ-008 The block SHALL have port out_data  output  WIDTH  shared payload bus to all channels.
REQ-009 The block SHALL have port out_valid  output  4  one-hot valid; bit k marks the payload for channel k.
REQ-010 The block SHALL have port out_ready  input  4  per-channel accept.

Function
REQ-011 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data and in_sel are captured together.
REQ-012 An output transfer SHALL occur on a rising edge where out_valid[k]=1 and out_ready[k]=1 for the head entry's channel k; out_ready bits of other channels SHALL be ignored.
REQ-013 Buffering SHALL be a 2-entry in-order FIFO with states EMPTY, ONE and FULL.
REQ-014 Transitions: EMPTY->ONE on input only; ONE->FULL on input without output; ONE->EMPTY on output without input; ONE->ONE on simultaneous input and output; FULL->ONE on output. Input in FULL is impossible.
REQ-015 in_ready SHALL be driven from a register, equal to (state != FULL), with no combinational path from out_ready.
REQ-016 out_valid SHALL be one-hot, decoded from the head entry's sel when state != EMPTY, and 4'b0000 in EMPTY; out_data SHALL equal the head entry's data, or 0 in EMPTY.
REQ-017 Latency SHALL be exactly one cycle from input transfer to out_valid when the FIFO was EMPTY; throughput SHALL be one payload per cycle when the head channel's out_ready is held high.
REQ-018 Order SHALL be preserved across channels: a stalled head entry SHALL block the second entry even if that entry targets a ready channel.
REQ-019 out_data and out_valid SHALL stay stable while the head entry is not accepted.

Reset
REQ-020 While rst_n=0 at a rising edge, state SHALL become EMPTY, in_ready SHALL become 0, and both entries SHALL be cleared; in_ready SHALL become 1 on the first edge with rst_n=1.
REQ-021 Reset mid-operation SHALL discard buffered payloads; no output transfer SHALL be reported on the reset edge.

Configuration
REQ-022 With macro DEMUX4_PIPE_COUNT_EN defined, the block SHALL add output port xfer_count  output  32, made of four 8-bit saturating counters, where byte k counts output transfers on channel k, cleared by reset, and holding at 255.
REQ-023 Without DEMUX4_PIPE_COUNT_EN, the port and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-024 Package demux4_pkg SHALL hold NUM_CH=4, SEL_W=2, the fifo_state_t enum (EMPTY, ONE, FULL) and the entry struct (data, sel).
REQ-025 The 2-entry FIFO SHALL be a sub-module named demux_skid2; the one-hot decode and the counters SHALL stay in demux4_pipe.

Verification
REQ-026 Reset then single payload: in_data=0xDEADBEEF, in_sel=2, out_ready=4'b1111 -> next cycle out_valid=4'b0100, out_data=0xDEADBEEF; the following cycle out_valid=0.
REQ-027 Back-to-back streaming: sel 0,1,2,3 on consecutive cycles with out_ready=4'b1111 -> out_valid 0001,0010,0100,1000 on consecutive cycles, and in_ready stays 1.
REQ-028 Fill to FULL: out_ready=0 and two inputs (sel=1 then sel=3) -> in_ready=0 on the cycle after the second input; set out_ready=4'b1000 -> no transfer (head targets channel 1); set out_ready=4'b0010 -> channel 1 drains, then in_ready=1.
REQ-029 Simultaneous input and output in ONE: the state stays ONE, data order is preserved, and no payload is lost or duplicated across 100 random-stall cycles (scoreboard).
REQ-030 Reset while FULL: rst_n=0 for one edge -> out_valid=0 and in_ready=0 during reset, in_ready=1 the cycle after, and no stale payload appears.
REQ-031 With DEMUX4_PIPE_COUNT_EN: 300 transfers on channel 0 and 5 on channel 3 -> xfer_count=32'h05_00_00_FF.

Source files
------------

// File: rtl/demux4_pkg.sv
// Shared types and constants for the 4-channel pipelined demultiplexer.
package demux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    // Entry layout at the default payload width; the top re-declares it for other widths.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
    } entry_t;

endpackage

// File: rtl/demux_skid2.sv
// Two-entry in-order FIFO; the consumer supplies head_ready for the current head entry.
//   state | meaning
//   EMPTY | no entry buffered
//   ONE   | head entry valid, second slot free
//   FULL  | both entries valid, upstream stalled
module demux_skid2
    import demux4_pkg::*;
#(
    parameter type ENTRY_T = entry_t
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  ENTRY_T      in_entry,
    input  logic        head_ready,
    output ENTRY_T      head,
    output fifo_state_t state
);

    fifo_state_t r_state;
    fifo_state_t w_state_nxt;
    ENTRY_T      r_ent0;
    ENTRY_T      r_ent1;
    ENTRY_T      w_ent0_nxt;
    ENTRY_T      w_ent1_nxt;
    logic        r_in_ready;
    logic        w_push;
    logic        w_pop;

    always_comb begin
        w_push      = in_valid & r_in_ready;
        w_pop       = (r_state != EMPTY) & head_ready;
        w_state_nxt = r_state;
        w_ent0_nxt  = r_ent0;
        w_ent1_nxt  = r_ent1;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ONE;
                    w_ent0_nxt  = in_entry;
                end
            end
            ONE: begin
                case ({w_push, w_pop})
                    2'b10: begin
                        w_state_nxt = FULL;
                        w_ent1_nxt  = in_entry;
                    end
                    2'b01: w_state_nxt = EMPTY;
                    2'b11: w_ent0_nxt  = in_entry;
                    default: ;
                endcase
            end
            FULL: begin
                if (w_pop) begin
                    w_state_nxt = ONE;
                    w_ent0_nxt  = r_ent1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
            r_ent0     <= '0;
            r_ent1     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
            r_ent0     <= w_ent0_nxt;
            r_ent1     <= w_ent1_nxt;
        end
    end

    assign in_ready = r_in_ready;
    assign head     = r_ent0;
    assign state    = r_state;

endmodule

// File: rtl/demux4_pipe.sv
// One-to-four pipelined demultiplexer with a shared data bus and one-hot valids.
// Define DEMUX4_PIPE_COUNT_EN to add per-channel saturating transfer counters (xfer_count).
module demux4_pipe
    import demux4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [WIDTH-1:0]  out_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready
`ifdef DEMUX4_PIPE_COUNT_EN
    ,
    output logic [31:0]       xfer_count
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
    } entry_w_t;

    entry_w_t    w_in_entry;
    entry_w_t    w_head;
    fifo_state_t w_state;
    logic        w_head_ready;
    logic        w_head_vld;

    assign w_in_entry.data = in_data;
    assign w_in_entry.sel  = in_sel;

    demux_skid2 #(
        .ENTRY_T (entry_w_t)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_entry   (w_in_entry),
        .head_ready (w_head_ready),
        .head       (w_head),
        .state      (w_state)
    );

    // Only the head entry's channel can pop; other out_ready bits are don't-care.
    assign w_head_vld   = (w_state != EMPTY);
    assign w_head_ready = out_ready[w_head.sel];
    assign out_valid    = w_head_vld ? (NUM_CH'(1) << w_head.sel) : '0;
    assign out_data     = w_head_vld ? w_head.data : '0;

`ifdef DEMUX4_PIPE_COUNT_EN
    logic [7:0] r_cnt [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt[k] <= '0;
            end else if (out_valid[k] && out_ready[k] && (r_cnt[k] != 8'hFF)) begin
                r_cnt[k] <= r_cnt[k] + 8'd1;
            end
        end
        assign xfer_count[8*k +: 8] = r_cnt[k];
    end
`endif

endmodule

// File: tb/tb_demux4_pipe.sv
// Self-checking bench for demux4_pipe against a queue-based reference model.
module tb_demux4_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
`ifdef DEMUX4_PIPE_COUNT_EN
    logic [31:0] xfer_count;
`endif

    always #5 clk = ~clk;

    demux4_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX4_PIPE_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
    } pl_t;

    pl_t q[$];
    bit  m_rdy;
    int  m_cnt[4];
    int  n_cmp  = 0;
    int  n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: a 2-deep in-order queue; ready reflects occupancy after the previous edge.
    task automatic model_edge();
        bit out_x, in_x;
        if (!rst_n) begin
            q.delete();
            m_rdy = 1'b0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else begin
            out_x = (q.size() > 0) && out_ready[q[0].sel];
            in_x  = in_valid && m_rdy;
            if (out_x) begin
                if (m_cnt[q[0].sel] < 255) m_cnt[q[0].sel]++;
                void'(q.pop_front());
            end
            if (in_x) q.push_back('{data: in_data, sel: in_sel});
            m_rdy = (q.size() < 2);
        end
    endtask

    task automatic check_outs(input string tag);
        logic [3:0]  ev;
        logic [31:0] ed;
        ev = 4'b0000;
        ed = 32'h0;
        if (q.size() > 0) begin
            ev = 4'b0001 << q[0].sel;
            ed = q[0].data;
        end
        chk({tag, ".valid"}, {28'h0, out_valid}, {28'h0, ev});
        chk({tag, ".data"}, out_data, ed);
        chk({tag, ".in_ready"}, {31'h0, in_ready}, {31'h0, m_rdy});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        m_rdy     = 1'b0;

        step("rst0");
        step("rst1");
        chk("rst.in_ready", {31'h0, in_ready}, 32'h0);
        rst_n = 1'b1;
        step("rel");
        chk("rel.in_ready", {31'h0, in_ready}, 32'h1);

        // single payload, one-cycle latency
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_sel = 2'd2; out_ready = 4'hF;
        step("single");
        chk("single.valid_c", {28'h0, out_valid}, 32'h4);
        chk("single.data_c", out_data, 32'hDEADBEEF);
        in_valid = 1'b0;
        step("single_after");
        chk("single.after_c", {28'h0, out_valid}, 32'h0);

        // back-to-back streaming
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = 2'(i); in_data = $urandom;
            step("stream");
            chk("stream.valid_c", {28'h0, out_valid}, 32'h1 << i);
            chk("stream.ready_c", {31'h0, in_ready}, 32'h1);
        end
        in_valid = 1'b0;
        step("stream_end");

        // fill to FULL, head blocks a ready second entry
        out_ready = 4'h0;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h1111_0001;
        step("fill1");
        in_sel = 2'd3; in_data = 32'h3333_0003;
        step("fill2");
        in_valid = 1'b0;
        chk("full.in_ready_c", {31'h0, in_ready}, 32'h0);
        out_ready = 4'b1000;
        step("blocked1");
        step("blocked2");
        chk("blocked.valid_c", {28'h0, out_valid}, 32'h2);
        chk("blocked.data_c", out_data, 32'h1111_0001);
        out_ready = 4'b0010;
        step("drain1");
        chk("drain.in_ready_c", {31'h0, in_ready}, 32'h1);
        chk("drain.valid_c", {28'h0, out_valid}, 32'h8);
        out_ready = 4'hF;
        step("drain2");
        chk("drain.empty_c", {28'h0, out_valid}, 32'h0);

        // random traffic with random stalls
        for (int i = 0; i < 200; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = 4'($urandom);
            step("rand");
        end
        in_valid = 1'b0; out_ready = 4'hF;
        step("rand_drain1");
        step("rand_drain2");
        chk("rand.empty_c", {28'h0, out_valid}, 32'h0);

        // reset while FULL
        out_ready = 4'h0; in_valid = 1'b1;
        in_sel = 2'd0; in_data = 32'hAAAA_0000;
        step("rfill1");
        in_sel = 2'd1; in_data = 32'hBBBB_0001;
        step("rfill2");
        rst_n = 1'b0; out_ready = 4'hF;
        step("rst_full");
        chk("rst_full.valid_c", {28'h0, out_valid}, 32'h0);
        chk("rst_full.in_ready_c", {31'h0, in_ready}, 32'h0);
        rst_n = 1'b0; in_valid = 1'b0;
        rst_n = 1'b1;
        step("rst_rel");
        chk("rst_rel.in_ready_c", {31'h0, in_ready}, 32'h1);
        chk("rst_rel.valid_c", {28'h0, out_valid}, 32'h0);
        step("rst_idle");

`ifdef DEMUX4_PIPE_COUNT_EN
        rst_n = 1'b0;
        step("cnt_rst");
        rst_n = 1'b1;
        step("cnt_rel");
        out_ready = 4'hF;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1; in_sel = 2'd0; in_data = $urandom;
            step("cnt0");
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_sel = 2'd3; in_data = $urandom;
            step("cnt3");
        end
        in_valid = 1'b0;
        step("cnt_idle1");
        step("cnt_idle2");
        chk("cnt.model", xfer_count,
            {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
        chk("cnt.value", xfer_count, 32'h0500_00FF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
